io_echo_tester: RTL and testbench

//  Host-side initiator for the UART echo path: transmits a byte sequence over tx and

---
 rtl/io_pkg.sv | 14 +
 rtl/uart_rx.sv | 64 ++++++
 rtl/uart_tx.sv | 49 ++++
 rtl/io_echo_tester.sv | 132 +++++++++++++
 tb/tb_io_echo_tester.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the UART echo tester and the mirror block.
// echo_state_t : initiator FSM states.
// DEF_CLK_FREQ / DEF_BAUD : default line timing shared by both ends.
// sat_inc16 : saturating 16-bit counter increment.
package io_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_NEXT} echo_state_t;

  localparam int DEF_CLK_FREQ = 12_000_000;
  localparam int DEF_BAUD     = 9_600;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver, no reset (registers power up idle).
// clk      : system clock
// rx       : serial line (asynchronous, synchronised here)
// rx_data  : last received byte
// rx_ready : one-cycle pulse when rx_data is updated (mid stop bit)
module uart_rx #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 9_600
) (
  input  logic       clk,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready
);
  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = (DIV / 2 > 0) ? DIV / 2 : 1;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

  logic          rx_s1   = 1'b1;
  logic          rx_s2   = 1'b1;
  logic          busy    = 1'b0;
  logic [CW-1:0] cnt     = '0;
  logic [3:0]    bit_idx = '0;
  logic [7:0]    shreg   = '0;
  logic [7:0]    data_r  = '0;
  logic          rdy_r   = 1'b0;
  logic [CW-1:0] target;

  // First interval reaches mid start bit; later ones step a full bit.
  assign target = (bit_idx == 4'd0) ? CW'(HALF - 1) : CW'(DIV - 1);

  always_ff @(posedge clk) begin
    rx_s1 <= rx;
    rx_s2 <= rx_s1;
    rdy_r <= 1'b0;
    if (!busy) begin
      if (!rx_s2) begin
        busy    <= 1'b1;
        cnt     <= '0;
        bit_idx <= '0;
      end
    end else if (cnt == target) begin
      cnt <= '0;
      if (bit_idx == 4'd0) begin
        if (rx_s2) busy <= 1'b0;   // glitch, not a real start bit
        else       bit_idx <= 4'd1;
      end else if (bit_idx == 4'd9) begin
        busy <= 1'b0;
        if (rx_s2) begin           // framing error drops the byte
          data_r <= shreg;
          rdy_r  <= 1'b1;
        end
      end else begin
        shreg   <= {rx_s2, shreg[7:1]};
        bit_idx <= bit_idx + 4'd1;
      end
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign rx_data  = data_r;
  assign rx_ready = rdy_r;
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, no reset (registers power up idle).
// clk      : system clock
// tx_start : one-cycle request, taken only while tx_busy=0
// tx_data  : byte to send, captured with tx_start
// tx       : serial line, idles high
// tx_busy  : high for the full 10-bit frame including the stop bit
module uart_tx #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 9_600
) (
  input  logic       clk,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt     = '0;
  logic [3:0]    bit_idx = '0;
  logic [9:0]    shreg   = '1;
  logic          busy_r  = 1'b0;

  always_ff @(posedge clk) begin
    if (!busy_r) begin
      if (tx_start) begin
        shreg   <= {1'b1, tx_data, 1'b0};
        busy_r  <= 1'b1;
        cnt     <= '0;
        bit_idx <= '0;
      end
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
      if (bit_idx == 4'd9) begin
        busy_r <= 1'b0;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        // Shift in ones so the line rests high once the stop bit is out.
        shreg   <= {1'b1, shreg[9:1]};
      end
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tx      = shreg[0];
  assign tx_busy = busy_r;
endmodule

// File: rtl/io_echo_tester.sv
// Host-side UART echo initiator: sends SEED, SEED+1, ... (8-bit wrap) over tx,
// waits for each byte to come back on rx and counts matches and misses.
// clk, rst           : clock, asynchronous active-high reset
// start              : begin a run (ignored while busy)
// rx / tx            : serial lines to / from the echoing side
// busy / done        : run in progress / run finished (held until next start)
// pass_count         : matching echoes (saturating)
// fail_count         : mismatches plus timeouts (saturating)
// last_sent/last_recv: most recent byte sent / accepted echo
module io_echo_tester
  import io_pkg::*;
#(
  parameter int         CLK_FREQ       = DEF_CLK_FREQ,
  parameter int         BAUD           = DEF_BAUD,
  parameter int         NUM_BYTES      = 256,
  parameter logic [7:0] SEED           = 8'h00,
  parameter int         TIMEOUT_CYCLES = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [15:0] pass_count,
  output logic [15:0] fail_count,
  output logic [7:0]  last_sent,
  output logic [7:0]  last_recv
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  echo_state_t   state, state_next;
  logic [15:0]   idx;
  logic [7:0]    data;
  logic [TW-1:0] timer;
  logic          tx_start;
  logic          tx_busy;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          timed_out;
  logic          last_byte;

  assign timed_out = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign last_byte = (idx == 16'(NUM_BYTES - 1));

  // last_sent always equals the byte in flight, so it feeds uart_tx directly.
  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tx (
    .clk     (clk),
    .tx_start(tx_start),
    .tx_data (last_sent),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk     (clk),
    .rx      (rx),
    .rx_data (rx_data),
    .rx_ready(rx_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)                 state_next = ST_LOAD;
      ST_LOAD: if (!tx_busy)              state_next = ST_WAIT;
      ST_WAIT: if (rx_ready || timed_out) state_next = ST_NEXT;
      ST_NEXT: state_next = last_byte ? ST_IDLE : ST_LOAD;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      last_sent  <= '0;
      last_recv  <= '0;
      tx_start   <= 1'b0;
      idx        <= '0;
      data       <= '0;
      timer      <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          pass_count <= '0;
          fail_count <= '0;
          done       <= 1'b0;
          idx        <= '0;
          data       <= SEED;
          busy       <= 1'b1;
        end
        // A frame left over from before a reset holds tx_busy; wait it out.
        ST_LOAD: if (!tx_busy) begin
          tx_start  <= 1'b1;
          last_sent <= data;
          timer     <= '0;
        end
        ST_WAIT: begin
          timer <= timer + TW'(1);
          // An echo in the timeout cycle is still compared, not counted as a miss.
          if (rx_ready) begin
            last_recv <= rx_data;
            if (rx_data == data) pass_count <= sat_inc16(pass_count);
            else                 fail_count <= sat_inc16(fail_count);
          end else if (timed_out) begin
            fail_count <= sat_inc16(fail_count);
          end
        end
        ST_NEXT: begin
          if (last_byte) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            idx  <= idx + 16'd1;
            data <= data + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_io_echo_tester.sv
// Bench for io_echo_tester: three instances with different NUM_BYTES/SEED share
// one clock and reset. A behavioural line decoder captures every byte on the
// selected tx; an echo responder can mirror, corrupt or drop bytes on rx.
module tb_io_echo_tester;
  localparam int M_LOOP = 0, M_HIGH = 1, M_BENCH = 2;
  localparam int BIT = 10;  // clocks per bit at 1 MHz / 100 kBd

  logic        clk = 1'b0;
  logic        rst;
  logic        start [3];
  logic        tx    [3];
  logic        rx    [3];
  logic        busy  [3];
  logic        done  [3];
  logic [15:0] pass_c [3];
  logic [15:0] fail_c [3];
  logic [7:0]  ls [3];
  logic [7:0]  lr [3];

  int   mode = M_LOOP;
  int   sel  = 0;
  logic rx_drv;
  logic sel_tx;

  int checks = 0;
  int errors = 0;

  logic [7:0] sent_q [$];
  logic [7:0] echo_q [$];
  int         bidx;
  logic [7:0] xv   [16];
  bit         drop [16];

  int         seed_of [3] = '{8'hA5, 8'hFE, 8'h3C};
  int         nb_of   [3] = '{4, 3, 2};

  always #5 clk = ~clk;

  assign rx[0] = (mode == M_LOOP) ? tx[0] : rx_drv;
  assign rx[1] = (mode == M_LOOP) ? tx[1] : rx_drv;
  assign rx[2] = (mode == M_LOOP) ? tx[2] : rx_drv;
  assign sel_tx = tx[sel];

  io_echo_tester #(.CLK_FREQ(1_000_000), .BAUD(100_000), .NUM_BYTES(4),
                   .SEED(8'hA5), .TIMEOUT_CYCLES(400)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .rx(rx[0]), .tx(tx[0]),
    .busy(busy[0]), .done(done[0]), .pass_count(pass_c[0]), .fail_count(fail_c[0]),
    .last_sent(ls[0]), .last_recv(lr[0]));

  io_echo_tester #(.CLK_FREQ(1_000_000), .BAUD(100_000), .NUM_BYTES(3),
                   .SEED(8'hFE), .TIMEOUT_CYCLES(400)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .rx(rx[1]), .tx(tx[1]),
    .busy(busy[1]), .done(done[1]), .pass_count(pass_c[1]), .fail_count(fail_c[1]),
    .last_sent(ls[1]), .last_recv(lr[1]));

  io_echo_tester #(.CLK_FREQ(1_000_000), .BAUD(100_000), .NUM_BYTES(2),
                   .SEED(8'h3C), .TIMEOUT_CYCLES(400)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .rx(rx[2]), .tx(tx[2]),
    .busy(busy[2]), .done(done[2]), .pass_count(pass_c[2]), .fail_count(fail_c[2]),
    .last_sent(ls[2]), .last_recv(lr[2]));

  // Line decoder: samples mid-bit, records the byte, queues the echo if asked.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge sel_tx);
      repeat (BIT + BIT / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        b[i] = sel_tx;
        repeat (BIT) @(posedge clk);
      end
      sent_q.push_back(b);
      if (mode == M_BENCH && bidx < 16 && !drop[bidx]) echo_q.push_back(b ^ xv[bidx]);
      bidx++;
    end
  end

  // Echo transmitter on rx_drv.
  initial begin
    logic [7:0] e;
    rx_drv = 1'b1;
    forever begin
      @(negedge clk);
      if (echo_q.size() > 0) begin
        e = echo_q.pop_front();
        rx_drv = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          rx_drv = e[i];
          repeat (BIT) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (BIT) @(negedge clk);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_model();
    sent_q.delete();
    echo_q.delete();
    bidx = 0;
    for (int k = 0; k < 16; k++) begin
      xv[k]   = 8'h00;
      drop[k] = 1'b0;
    end
  endtask

  task automatic pulse_start(input int s);
    @(negedge clk); start[s] = 1'b1;
    @(negedge clk); start[s] = 1'b0;
  endtask

  task automatic wait_done(input int s, input int bound);
    for (int k = 0; k < bound && !done[s]; k++) @(negedge clk);
    chk("run_done", int'(done[s]), 1);
  endtask

  task automatic chk_sent(input int s, input int first);
    for (int k = 0; k < nb_of[s]; k++)
      chk("sent_byte", (first + k < sent_q.size()) ? int'(sent_q[first + k]) : -1,
          (seed_of[s] + k) & 255);
  endtask

  typedef struct {
    int sel; int mode; int x1; int ep; int ef; int el;
  } vec_t;
  vec_t tbl [5];

  initial begin
    int ep, ef, el, r;
    logic [7:0] exp_b;
    tbl[0] = '{0, M_LOOP,  0,     4, 0, 'hA8};  // basic loopback
    tbl[1] = '{1, M_LOOP,  0,     3, 0, 'h00};  // FE,FF,00 wrap
    tbl[2] = '{2, M_HIGH,  0,     0, 2, 'h00};  // no echo: two timeouts
    tbl[3] = '{1, M_BENCH, 'h01,  2, 1, 'h00};  // corrupt 2nd byte
    tbl[4] = '{1, M_BENCH, 0,     3, 0, 'h00};  // clean bench echo

    for (int s = 0; s < 3; s++) start[s] = 1'b0;
    clear_model();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_pass", int'(pass_c[0]), 0);
    chk("rst_fail", int'(fail_c[0]), 0);
    chk("rst_last_sent", int'(ls[0]), 0);
    chk("rst_last_recv", int'(lr[0]), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Table-driven runs.
    for (int t = 0; t < 5; t++) begin
      sel  = tbl[t].sel;
      mode = tbl[t].mode;
      clear_model();
      xv[1] = 8'(tbl[t].x1);
      pulse_start(sel);
      chk("busy_in_run", int'(busy[sel]), 1);
      wait_done(sel, 4000);
      repeat (30) @(negedge clk);
      chk("pass", int'(pass_c[sel]), tbl[t].ep);
      chk("fail", int'(fail_c[sel]), tbl[t].ef);
      chk("last_recv", int'(lr[sel]), tbl[t].el);
      chk("last_sent", int'(ls[sel]), (seed_of[sel] + nb_of[sel] - 1) & 255);
      chk("busy_after", int'(busy[sel]), 0);
      chk("sent_count", sent_q.size(), nb_of[sel]);
      chk_sent(sel, 0);
    end

    // Randomised echo behaviour on instance b against a counting model.
    sel  = 1;
    mode = M_BENCH;
    el   = 8'h00;  // last_recv left by the final table row
    for (int run = 0; run < 6; run++) begin
      clear_model();
      ep = 0; ef = 0;
      for (int k = 0; k < nb_of[1]; k++) begin
        r = $urandom_range(0, 2);
        exp_b = 8'((seed_of[1] + k) & 255);
        if (r == 2) begin
          drop[k] = 1'b1;
          ef++;
        end else begin
          if (r == 1) xv[k] = 8'($urandom_range(1, 255));
          if (xv[k] == 8'h00) ep++; else ef++;
          el = int'(exp_b ^ xv[k]);
        end
      end
      pulse_start(1);
      wait_done(1, 4000);
      repeat (30) @(negedge clk);
      chk("rnd_pass", int'(pass_c[1]), ep);
      chk("rnd_fail", int'(fail_c[1]), ef);
      chk("rnd_last_recv", int'(lr[1]), el);
      chk_sent(1, 0);
    end

    // Reset in the middle of a wait: uart_tx frame finishes on its own and
    // the next run starts only after it.
    sel  = 0;
    mode = M_LOOP;
    clear_model();
    pulse_start(0);
    for (int k = 0; k < 200 && tx[0]; k++) @(negedge clk);
    chk("rst_mid_frame_started", int'(tx[0]), 0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", int'(busy[0]), 0);
    chk("midrst_done", int'(done[0]), 0);
    chk("midrst_pass", int'(pass_c[0]), 0);
    chk("midrst_fail", int'(fail_c[0]), 0);
    chk("midrst_last_sent", int'(ls[0]), 0);
    chk("midrst_last_recv", int'(lr[0]), 0);
    rst = 1'b0;
    pulse_start(0);
    wait_done(0, 4000);
    repeat (30) @(negedge clk);
    chk("midrst_run_pass", int'(pass_c[0]), 4);
    chk("midrst_run_fail", int'(fail_c[0]), 0);
    chk("midrst_run_last_recv", int'(lr[0]), 'hA8);
    chk("midrst_frames", sent_q.size(), 5);
    chk("midrst_old_frame", (sent_q.size() > 0) ? int'(sent_q[0]) : -1, 'hA5);
    chk_sent(0, 1);

    // start while busy is ignored; stray echo in idle is dropped.
    clear_model();
    pulse_start(0);
    repeat (50) @(negedge clk);
    pulse_start(0);
    wait_done(0, 4000);
    repeat (600) @(negedge clk);
    chk("busy_start_pass", int'(pass_c[0]), 4);
    chk("busy_start_fail", int'(fail_c[0]), 0);
    chk("no_extra_run", sent_q.size(), 4);
    chk("idle_busy", int'(busy[0]), 0);
    chk("done_held", int'(done[0]), 1);
    mode = M_BENCH;
    echo_q.push_back(8'h5A);
    repeat (150) @(negedge clk);
    chk("stray_pass", int'(pass_c[0]), 4);
    chk("stray_fail", int'(fail_c[0]), 0);
    chk("stray_last_recv", int'(lr[0]), 'hA8);
    chk("stray_busy", int'(busy[0]), 0);

    // start while done=1 launches a fresh run.
    clear_model();
    pulse_start(0);
    chk("restart_done_clr", int'(done[0]), 0);
    chk("restart_busy", int'(busy[0]), 1);
    wait_done(0, 4000);
    repeat (30) @(negedge clk);
    chk("restart_pass", int'(pass_c[0]), 4);
    chk("restart_fail", int'(fail_c[0]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
